// File: rtl/aes_pkg.sv
// Shared AES constants: key-length codes, round counts, rcon values,
// key-schedule controller states and the GF(2^8) xtime helper.
package aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_RESET = 8'h8d;

    typedef enum logic {
        CTRL_IDLE     = 1'b0,
        CTRL_GENERATE = 1'b1
    } ctrl_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Index of the final round key for a given key length.
    function automatic logic [3:0] last_round(input logic keylen);
        return (keylen == AES_256_BIT_KEY) ? AES_256_NUM_ROUNDS : AES_128_NUM_ROUNDS;
    endfunction

endpackage

// File: rtl/aes_key_mem_if.sv
// Bus between the key memory and its user. The user side also returns the
// shared S-box result, so new_sboxw is driven from the master modport.
interface aes_key_mem_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_mem_next.sv
// Combinational next-round-key step of the AES key schedule. AES-128 and
// even AES-256 steps apply RotWord and rcon; odd AES-256 steps use plain
// SubWord and derive from the key two steps back.
module aes_key_mem_next
    import aes_pkg::*;
(
    input  logic [127:0] prev_key0,
    input  logic [127:0] prev_key1,
    input  logic [31:0]  new_sboxw,
    input  logic [7:0]   rcon,
    input  logic         keylen,
    input  logic         round_odd,
    output logic [127:0] next_key,
    output logic         used_rcon
);

    logic [127:0] base;
    logic [31:0]  t;
    logic [31:0]  w0, w1, w2, w3;

    // Select base key and the transformed word, then chain the XORs.
    always_comb begin
        base      = prev_key1;
        t         = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0};
        used_rcon = 1'b1;
        if (keylen == AES_256_BIT_KEY) begin
            base = prev_key0;
            if (round_odd) begin
                t         = new_sboxw;
                used_rcon = 1'b0;
            end
        end
        w0       = base[127:96] ^ t;
        w1       = base[95:64]  ^ w0;
        w2       = base[63:32]  ^ w1;
        w3       = base[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_key_mem.sv
// AES round-key generator and 15-entry store. Expands one round key per
// cycle after an init pulse and serves round_key combinationally.
// Optional build macro AES_KEY_MEM_RANGE_GUARD_EN: zero round_key for
// out-of-range rounds or while not ready, and clear entries 11..14 on an
// AES-128 init.
module aes_key_mem
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    aes_key_mem_if.slave bus
);

    logic [127:0] key_mem [0:14];
    logic [127:0] prev_key0;
    logic [127:0] prev_key1;
    logic [7:0]   rcon;
    logic [3:0]   round_ctr;
    logic         keylen_reg;
    logic         ready_reg;

    ctrl_state_t  state;
    ctrl_state_t  state_next;
    logic         load;
    logic         step;
    logic         done;

    logic [127:0] next_key;
    logic         used_rcon;

    aes_key_mem_next u_next (
        .prev_key0 (prev_key0),
        .prev_key1 (prev_key1),
        .new_sboxw (bus.new_sboxw),
        .rcon      (rcon),
        .keylen    (keylen_reg),
        .round_odd (round_ctr[0]),
        .next_key  (next_key),
        .used_rcon (used_rcon)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CTRL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; init is only honoured while idle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (bus.init) begin
                    load       = 1'b1;
                    state_next = CTRL_GENERATE;
                end
            end
            CTRL_GENERATE: begin
                step = 1'b1;
                if (round_ctr == last_round(keylen_reg)) begin
                    done       = 1'b1;
                    state_next = CTRL_IDLE;
                end
            end
            default: state_next = CTRL_IDLE;
        endcase
    end

    // Key storage, schedule registers and ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++) begin
                key_mem[i] <= '0;
            end
            prev_key0  <= '0;
            prev_key1  <= '0;
            rcon       <= RCON_RESET;
            round_ctr  <= '0;
            keylen_reg <= AES_128_BIT_KEY;
            ready_reg  <= 1'b0;
        end else if (load) begin
            key_mem[0] <= bus.key[255:128];
            keylen_reg <= bus.keylen;
            rcon       <= RCON_INIT;
            ready_reg  <= 1'b0;
            if (bus.keylen == AES_256_BIT_KEY) begin
                key_mem[1] <= bus.key[127:0];
                prev_key0  <= bus.key[255:128];
                prev_key1  <= bus.key[127:0];
                round_ctr  <= 4'd2;
            end else begin
                prev_key1 <= bus.key[255:128];
                round_ctr <= 4'd1;
`ifdef AES_KEY_MEM_RANGE_GUARD_EN
                for (int i = 11; i < 15; i++) begin
                    key_mem[i] <= '0;
                end
`endif
            end
        end else if (step) begin
            key_mem[round_ctr] <= next_key;
            prev_key0          <= prev_key1;
            prev_key1          <= next_key;
            round_ctr          <= round_ctr + 4'd1;
            if (used_rcon) begin
                rcon <= xtime(rcon);
            end
            if (done) begin
                ready_reg <= 1'b1;
            end
        end
    end

    // Combinational round-key read; index 15 has no entry and reads zero.
    always_comb begin
        bus.round_key = '0;
`ifdef AES_KEY_MEM_RANGE_GUARD_EN
        if (ready_reg && (bus.round <= last_round(keylen_reg))) begin
            bus.round_key = key_mem[bus.round];
        end
`else
        if (bus.round != 4'd15) begin
            bus.round_key = key_mem[bus.round];
        end
`endif
    end

    assign bus.sboxw = prev_key1[31:0];
    assign bus.ready = ready_reg;

endmodule

// File: tb/tb_aes_key_mem.sv
// Self-checking bench for aes_key_mem: a behavioural S-box answers the
// sboxw requests and a word-level FIPS-197 key expansion predicts the
// stored schedule.
module tb_aes_key_mem;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;

    aes_key_mem_if bif ();

    aes_key_mem dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8b(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8b(inv, 1) ^ rotl8b(inv, 2) ^ rotl8b(inv, 3) ^ rotl8b(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Shared S-box answering in the same cycle.
    always_comb bif.new_sboxw = sub_word(bif.sboxw);

    // Reference state.
    logic [127:0] rk_m  [0:14];
    logic [127:0] mem_m [0:14];
    logic         rdy_m;
    logic         kl_m;
    logic [31:0]  sboxw_m;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word-oriented key expansion straight from FIPS-197.
    task automatic model_expand(input logic [255:0] k, input logic kl);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int r = 0; r < 15; r++) begin
            rk_m[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'h0;
        end
    endtask

    task automatic model_load(input logic [255:0] k, input logic kl);
        int nr;
        nr = kl ? 14 : 10;
        model_expand(k, kl);
        for (int r = 0; r <= nr; r++) mem_m[r] = rk_m[r];
`ifdef AES_KEY_MEM_RANGE_GUARD_EN
        if (!kl) for (int r = 11; r < 15; r++) mem_m[r] = 128'h0;
`endif
        kl_m    = kl;
        rdy_m   = 1'b0;
        sboxw_m = rk_m[nr][31:0];
    endtask

    task automatic model_reset();
        for (int r = 0; r < 15; r++) mem_m[r] = 128'h0;
        rdy_m   = 1'b0;
        kl_m    = 1'b0;
        sboxw_m = 32'h0;
    endtask

    function automatic logic [127:0] exp_read(input int r);
        if (r == 15) return 128'h0;
`ifdef AES_KEY_MEM_RANGE_GUARD_EN
        if (!rdy_m || r > (kl_m ? 14 : 10)) return 128'h0;
`endif
        return mem_m[r];
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_round(input string tag, input int r, input logic [127:0] exp);
        bif.round = 4'(r);
        #1;
        check_value(tag, bif.round_key, exp);
    endtask

    task automatic check_reads(input string tag);
        for (int r = 0; r < 16; r++) begin
            bif.round = 4'(r);
            #1;
            check_value($sformatf("%s_rk%0d", tag, r), bif.round_key, exp_read(r));
        end
        check_value({tag, "_ready"}, {127'h0, bif.ready}, {127'h0, rdy_m});
        check_value({tag, "_sboxw"}, {96'h0, bif.sboxw}, {96'h0, sboxw_m});
    endtask

    // Pulse init, optionally poke a second init or pulse reset mid-run, and
    // measure edges from the init edge to ready.
    task automatic run_exp(input string tag, input logic [255:0] k, input logic kl,
                           input logic poke, input logic [255:0] k2, input int rst_at);
        int cnt;
        @(negedge clk);
        bif.init   = 1'b1;
        bif.key    = k;
        bif.keylen = kl;
        @(negedge clk);
        bif.init = 1'b0;
        cnt      = 0;
        model_load(k, kl);
        check_value({tag, "_rdy_clr"}, {127'h0, bif.ready}, 128'h0);
        bif.key    = rand_key();
        bif.keylen = ~kl;
        while (!bif.ready && cnt < 40) begin
            bif.init = (poke && cnt == 3);
            if (poke && cnt == 3) bif.key = k2;
            if (rst_at == cnt) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_value({tag, "_rst_ready"}, {127'h0, bif.ready}, 128'h0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            @(negedge clk);
            cnt++;
        end
        bif.init = 1'b0;
        check_value({tag, "_latency"}, 128'(cnt), kl ? 128'd13 : 128'd10);
        rdy_m = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k;
        logic         kl;
        n_total    = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        bif.init   = 1'b0;
        bif.key    = '0;
        bif.keylen = 1'b0;
        bif.round  = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reads("reset");

        run_exp("fips128", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdef0011223344556677},
                1'b0, 1'b0, '0, -1);
        check_round("fips128_r1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        check_round("fips128_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_reads("fips128");

        run_exp("seq128", {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0, 1'b0, '0, -1);
        check_round("seq128_r0", 0, 128'h000102030405060708090a0b0c0d0e0f);
        check_round("seq128_r10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        run_exp("seq256", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                1'b1, 1'b0, '0, -1);
        check_round("seq256_r1", 1, 128'h101112131415161718191a1b1c1d1e1f);
        check_round("seq256_r14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check_reads("seq256");

        run_exp("poke128", rand_key(), 1'b0, 1'b1, rand_key(), -1);
        check_reads("poke128");

        run_exp("rst256", rand_key(), 1'b1, 1'b0, '0, 5);
        @(negedge clk);
        check_reads("rst256");
        run_exp("after_rst", rand_key(), 1'b1, 1'b0, '0, -1);
        check_reads("after_rst");

        for (int i = 0; i < 6; i++) begin
            k  = rand_key();
            kl = 1'($urandom_range(0, 1));
            run_exp($sformatf("rand%0d", i), k, kl, 1'b0, '0, -1);
            check_reads($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
